// File: rtl/shift_pkg.sv
// Shared definitions for the sequential right shifter: FSM state encoding.
package shift_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } shift_seq_state_t;

endpackage : shift_pkg

// File: rtl/polyshift_r_cf.sv
// Carry-out of a single right shift by shift_size_i: the last bit shifted out,
// or the incoming carry when the shift size is zero.
module polyshift_r_cf #(
   parameter int WORD_WIDTH = 8,
   parameter int STEP_WIDTH = $clog2(WORD_WIDTH)
) (
   input  logic                  cf_i,
   input  logic [STEP_WIDTH-1:0] shift_size_i,
   input  logic [WORD_WIDTH-2:0] data_i,
   output logic                  cf_o
);

   // Step never exceeds WORD_WIDTH-1, so data_i[step-1] is always in range.
   always_comb begin
      cf_o = cf_i;
      for (int i = 1; i < WORD_WIDTH; i++) begin
         if (shift_size_i == STEP_WIDTH'(i)) cf_o = data_i[i-1];
      end
   end

endmodule : polyshift_r_cf

// File: rtl/shift_seq_r.sv
// Multi-cycle right shifter: shifts by up to WORD_WIDTH-1 bits per RUN cycle.
// Optional macro SHIFT_SEQ_R_ARITH_EN adds arith_i (sign fill instead of zero fill).
// Handshake: a transfer happens on a channel in any cycle where valid & ready are both high;
// flush_i wins over both handshakes, and reset wins over everything.
module shift_seq_r
   import shift_pkg::*;
#(
   parameter int WORD_WIDTH  = 8,
   parameter int COUNT_WIDTH = $clog2(WORD_WIDTH) + 2
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   input  logic [WORD_WIDTH-1:0]  data_i,
   input  logic [COUNT_WIDTH-1:0] count_i,
   input  logic                   cf_i,
`ifdef SHIFT_SEQ_R_ARITH_EN
   input  logic                   arith_i,
`endif
   input  logic                   flush_i,
   output logic                   resp_valid_o,
   input  logic                   resp_ready_i,
   output logic [WORD_WIDTH-1:0]  data_o,
   output logic                   cf_o,
   output logic                   busy_o
);

   localparam int STEP_WIDTH = $clog2(WORD_WIDTH);
   localparam logic [COUNT_WIDTH-1:0] MAX_STEP = COUNT_WIDTH'(WORD_WIDTH - 1);

   shift_seq_state_t state, state_next;

   logic [WORD_WIDTH-1:0]  data_q;
   logic                   cf_q;
   logic [COUNT_WIDTH-1:0] rem_q;
   logic                   fill_q;

   logic [COUNT_WIDTH-1:0] step_c;
   logic [STEP_WIDTH-1:0]  step_s;
   logic [COUNT_WIDTH-1:0] rem_next;
   logic [WORD_WIDTH-1:0]  shifted;
   logic                   cf_step;
   logic                   accept;
   logic                   fill_in;

   assign accept = req_valid_i & req_ready_o;

`ifdef SHIFT_SEQ_R_ARITH_EN
   assign fill_in = arith_i & data_i[WORD_WIDTH-1];
`else
   assign fill_in = 1'b0;
`endif

   always_comb begin
      step_c = (rem_q > MAX_STEP) ? MAX_STEP : rem_q;
   end

   assign step_s   = step_c[STEP_WIDTH-1:0];
   assign rem_next = rem_q - step_c;

   // Sign fill is a zero-fill shift of the inverted word, inverted back.
   always_comb begin
      if (fill_q) shifted = ~((~data_q) >> step_c);
      else        shifted = data_q >> step_c;
   end

   polyshift_r_cf #(
      .WORD_WIDTH (WORD_WIDTH),
      .STEP_WIDTH (STEP_WIDTH)
   ) u_cf (
      .cf_i         (cf_q),
      .shift_size_i (step_s),
      .data_i       (data_q[WORD_WIDTH-2:0]),
      .cf_o         (cf_step)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = (count_i == '0) ? DONE : RUN;
         RUN:     if (rem_next == '0) state_next = DONE;
         DONE:    if (resp_valid_o && resp_ready_i) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (flush_i) state_next = IDLE;
   end

   always_comb begin
      req_ready_o  = (state == IDLE);
      resp_valid_o = (state == DONE);
      busy_o       = (state != IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         data_q <= '0;
         cf_q   <= 1'b0;
         rem_q  <= '0;
         fill_q <= 1'b0;
      end else if (!flush_i) begin
         if (accept) begin
            data_q <= data_i;
            cf_q   <= cf_i;
            rem_q  <= count_i;
            fill_q <= fill_in;
         end else if (state == RUN) begin
            data_q <= shifted;
            cf_q   <= cf_step;
            rem_q  <= rem_next;
         end
      end
   end

   assign data_o = data_q;
   assign cf_o   = cf_q;

endmodule : shift_seq_r

// File: tb/tb_shift_seq_r.sv
// Self-checking bench for shift_seq_r: directed cases, hold, flush/reset abort, random requests.
module tb_shift_seq_r;

   localparam int W  = 8;
   localparam int CW = $clog2(W) + 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic [W-1:0]  data_in;
   logic [CW-1:0] count_in;
   logic          cf_in;
   logic          arith;
   logic          flush;
   logic          resp_valid;
   logic          resp_ready;
   logic [W-1:0]  data_out;
   logic          cf_out;
   logic          busy;

   int checks   = 0;
   int failures = 0;
   logic [W:0] exp_q[$];

   shift_seq_r #(.WORD_WIDTH(W), .COUNT_WIDTH(CW)) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .data_i       (data_in),
      .count_i      (count_in),
      .cf_i         (cf_in),
`ifdef SHIFT_SEQ_R_ARITH_EN
      .arith_i      (arith),
`endif
      .flush_i      (flush),
      .resp_valid_o (resp_valid),
      .resp_ready_i (resp_ready),
      .data_o       (data_out),
      .cf_o         (cf_out),
      .busy_o       (busy)
   );

   always #5 clk = ~clk;

   // Reference: shift one bit at a time, carry = bit that falls off the bottom.
   function automatic logic [W:0] model(input logic [W-1:0] d, input int cnt,
                                        input logic c, input logic ar);
      logic s;
      s = ar & d[W-1];
      for (int i = 0; i < cnt; i++) begin
         c = d[0];
         d = {s, d[W-1:1]};
      end
      return {c, d};
   endfunction

   function automatic int latency(input int cnt);
      return (cnt == 0) ? 1 : 1 + (cnt + W - 2) / (W - 1);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_req(input logic [W-1:0] d, input int cnt, input logic c,
                          input logic ar, input int hold, input string tag);
      logic [W:0] exp;
      int waited;
      int lat;
      exp_q.push_back(model(d, cnt, c, ar));
      waited = 0;
      while (!req_ready && waited < 50) begin
         tick();
         waited++;
      end
      checks++;
      if (req_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s ready_timeout got=%b want=1", tag, req_ready);
      end
      req_valid = 1'b1;
      data_in   = d;
      count_in  = cnt[CW-1:0];
      cf_in     = c;
      arith     = ar;
      tick();
      req_valid = 1'b0;
      data_in   = $urandom_range(0, 255);
      lat = 1;
      while (!resp_valid && lat < 200) begin
         tick();
         lat++;
      end
      exp = exp_q.pop_front();
      checks++;
      if (lat !== latency(cnt)) begin
         failures++;
         $display("FAIL %s latency got=%0d want=%0d", tag, lat, latency(cnt));
      end
      checks++;
      if (data_out !== exp[W-1:0]) begin
         failures++;
         $display("FAIL %s data got=%h want=%h", tag, data_out, exp[W-1:0]);
      end
      checks++;
      if (cf_out !== exp[W]) begin
         failures++;
         $display("FAIL %s cf got=%b want=%b", tag, cf_out, exp[W]);
      end
      for (int i = 0; i < hold; i++) begin
         tick();
         checks++;
         if ({resp_valid, req_ready, cf_out, data_out} !== {1'b1, 1'b0, exp}) begin
            failures++;
            $display("FAIL %s hold%0d got v=%b r=%b cf=%b d=%h want v=1 r=0 cf=%b d=%h",
                     tag, i, resp_valid, req_ready, cf_out, data_out, exp[W], exp[W-1:0]);
         end
      end
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      checks++;
      if ({req_ready, resp_valid, busy} !== 3'b100) begin
         failures++;
         $display("FAIL %s release got rdy/vld/busy=%b want=100", tag, {req_ready, resp_valid, busy});
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      checks++;
      if ({req_ready, resp_valid, busy, cf_out, data_out} !== {4'b1000, {W{1'b0}}}) begin
         failures++;
         $display("FAIL reset got rdy=%b vld=%b busy=%b cf=%b d=%h want 1 0 0 0 00",
                  req_ready, resp_valid, busy, cf_out, data_out);
      end
   endtask

   task automatic test_directed();
      checks++;
      if (model(8'hB5, 3, 1'b0, 1'b0) !== {1'b1, 8'h16}) begin
         failures++;
         $display("FAIL model_sanity got=%h want=116", model(8'hB5, 3, 1'b0, 1'b0));
      end
      run_req(8'hB5, 3,  1'b0, 1'b0, 0, "b5_c3");
      run_req(8'hB5, 0,  1'b1, 1'b0, 0, "b5_c0");
      run_req(8'hB5, 7,  1'b0, 1'b0, 0, "b5_c7");
      run_req(8'hB5, 8,  1'b0, 1'b0, 0, "b5_c8");
      run_req(8'hB5, 10, 1'b1, 1'b0, 0, "b5_c10");
      run_req(8'hFF, 31, 1'b1, 1'b0, 0, "ff_c31");
   endtask

   task automatic test_arith();
`ifdef SHIFT_SEQ_R_ARITH_EN
      run_req(8'hB5, 3,  1'b0, 1'b1, 0, "arith_c3");
      run_req(8'hB5, 12, 1'b0, 1'b1, 0, "arith_c12");
      run_req(8'h35, 12, 1'b1, 1'b1, 0, "arith_pos");
`endif
   endtask

   task automatic test_hold();
      run_req(8'hB5, 3, 1'b0, 1'b0, 5, "hold");
   endtask

   task automatic test_abort(input bit use_reset, input string tag);
      req_valid = 1'b1;
      data_in   = 8'hB5;
      count_in  = CW'(20);
      cf_in     = 1'b0;
      arith     = 1'b0;
      tick();
      req_valid = 1'b0;
      tick();
      checks++;
      if ({busy, resp_valid} !== 2'b10) begin
         failures++;
         $display("FAIL %s in_run got busy/vld=%b want=10", tag, {busy, resp_valid});
      end
      if (use_reset) rst_n = 1'b0;
      else           flush = 1'b1;
      tick();
      rst_n = 1'b1;
      flush = 1'b0;
      checks++;
      if ({req_ready, resp_valid, busy} !== 3'b100) begin
         failures++;
         $display("FAIL %s idle got rdy/vld/busy=%b want=100", tag, {req_ready, resp_valid, busy});
      end
      if (use_reset) begin
         checks++;
         if ({cf_out, data_out} !== '0) begin
            failures++;
            $display("FAIL %s regs got cf=%b d=%h want cf=0 d=00", tag, cf_out, data_out);
         end
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s no_resp%0d got=%b want=0", tag, i, resp_valid);
         end
      end
   endtask

   task automatic test_flush_vs_accept();
      req_valid = 1'b1;
      count_in  = CW'(2);
      flush     = 1'b1;
      tick();
      req_valid = 1'b0;
      flush     = 1'b0;
      checks++;
      if ({req_ready, busy} !== 2'b10) begin
         failures++;
         $display("FAIL flush_accept got rdy/busy=%b want=10", {req_ready, busy});
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         run_req(W'($urandom_range(0, 255)), $urandom_range(0, (1 << CW) - 1),
                 1'($urandom_range(0, 1)),
`ifdef SHIFT_SEQ_R_ARITH_EN
                 1'($urandom_range(0, 1)),
`else
                 1'b0,
`endif
                 $urandom_range(0, 2), "random");
      end
   endtask

   initial begin
      req_valid  = 1'b0;
      data_in    = '0;
      count_in   = '0;
      cf_in      = 1'b0;
      arith      = 1'b0;
      flush      = 1'b0;
      resp_ready = 1'b0;
      rst_n      = 1'b0;
      test_reset();
      test_directed();
      test_arith();
      test_hold();
      test_abort(1'b0, "flush_run");
      test_abort(1'b1, "reset_run");
      test_flush_vs_accept();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_shift_seq_r

// File: doc/shift_seq_r.md
SHIFT_SEQ_R -- requirements
Module: shift_seq_r

Interface
REQ-001 Parameter WORD_WIDTH, default 8: data word width; SHALL be >= 2.
REQ-002 Parameter COUNT_WIDTH, default $clog2(WORD_WIDTH)+2: width of the requested total shift count.
REQ-003 clk_i  input  1  the only clock; all state changes on its rising edge.
REQ-004 rst_n_i  input  1  reset, synchronous to clk_i, active-low.
REQ-005 req_valid_i  input  1  a request is present on the request inputs.
REQ-006 req_ready_o  output  1  the block accepts a request this cycle.
REQ-007 data_i  input  WORD_WIDTH  word to shift right.
REQ-008 count_i  input  COUNT_WIDTH  total right-shift distance; may be >= WORD_WIDTH.
REQ-009 cf_i  input  1  carry flag input; returned unchanged when count_i = 0.
REQ-010 flush_i  input  1  abort any operation in progress.
REQ-011 resp_valid_o  output  1  result is valid.
REQ-012 resp_ready_i  input  1  consumer takes the result.
REQ-013 data_o  output  WORD_WIDTH  shifted word.
REQ-014 cf_o  output  1  last bit shifted out, or cf_i if count_i = 0.
REQ-015 busy_o  output  1  high whenever the state is not IDLE.

Function
REQ-016 FSM states SHALL be IDLE, RUN and DONE. req_ready_o SHALL be 1 only in IDLE. resp_valid_o SHALL be 1 only in DONE.
REQ-017 Accept occurs when req_valid_i & req_ready_o. On accept, the block SHALL register data_i, cf_i and count_i as the remaining count.
- Next state is DONE if count_i = 0, else RUN.
REQ-018 Each RUN cycle: step = min(remaining, WORD_WIDTH-1).
- cf_next = (step == 0) ? cf : data[step-1].
- data_next = data >> step, with fill 0.
- remaining decrements by step.
REQ-019 RUN SHALL go to DONE in the cycle where remaining reaches 0, so the number of RUN cycles is ceil(count/(WORD_WIDTH-1)).
REQ-020 Latency from accept to resp_valid_o SHALL be 1 cycle for count 0, and 1 + ceil(count/(WORD_WIDTH-1)) cycles otherwise.
REQ-021 In DONE, data_o and cf_o SHALL stay stable until resp_ready_i; on resp_valid_o & resp_ready_i the next state SHALL be IDLE.
- A new accept is possible one cycle later; there is no DONE-to-accept bypass.
REQ-022 Counts >= WORD_WIDTH SHALL yield data_o = fill pattern and cf_o = the last real bit shifted out, which is the fill value once count > WORD_WIDTH.
REQ-023 flush_i SHALL force the next state to IDLE from any state.
- flush_i wins over a simultaneous accept or response handshake; the result is discarded.
REQ-024 data_o and cf_o SHALL reflect the internal registers in all states; they are meaningful only while resp_valid_o is high.

Reset
REQ-025 With rst_n_i low at a clock edge, the state SHALL become IDLE and the internal data, cf and remaining registers SHALL become 0.
- Resulting outputs: req_ready_o=1 after reset deasserts, resp_valid_o=0, busy_o=0, data_o=0, cf_o=0.
REQ-026 Reset asserted mid-RUN or in DONE SHALL discard the operation with no response; reset has priority over flush_i and all handshakes.

Configuration
REQ-027 Macro SHIFT_SEQ_R_ARITH_EN, when defined, SHALL add input port arith_i (1 bit), registered on accept.
- arith_i=1 selects fill = original data_i[WORD_WIDTH-1] (sign) instead of 0; cf follows the same per-step rule.
REQ-028 Without SHIFT_SEQ_R_ARITH_EN, the port arith_i SHALL NOT exist and fill SHALL always be 0.

Structure
REQ-029 A shared package shift_pkg SHALL hold the FSM state enum shift_seq_state_t (IDLE, RUN, DONE).
REQ-030 The per-step carry SHALL be computed by one instance of polyshift_r_cf:
- cf_i = current cf
- shift_size_i = step
- data_i = data[WORD_WIDTH-2:0]
REQ-031 The data shift, step computation and FSM SHALL be local logic; there SHALL be no other sub-modules.

Verification (WORD_WIDTH=8)
REQ-032 Request data 0xB5, count 3, cf_i=0 -> 1 RUN cycle; resp_valid_o 2 cycles after accept with data_o=0x16, cf_o=1.
REQ-033 Request 0xB5, count 0, cf_i=1 -> resp_valid_o 1 cycle after accept with data_o=0xB5, cf_o=1.
REQ-034 Request 0xB5, count 8 -> 2 RUN cycles (steps 7, then 1); data_o=0x00, cf_o=1; with count 10 -> data_o=0x00, cf_o=0.
REQ-035 SHIFT_SEQ_R_ARITH_EN defined, request 0xB5, count 3, arith_i=1 -> data_o=0xF6, cf_o=1; count 12 -> data_o=0xFF, cf_o=1.
REQ-036 Hold resp_ready_i low 5 cycles in DONE -> data_o, cf_o and resp_valid_o stay stable, req_ready_o=0; release -> IDLE next cycle.
REQ-037 Count 20: assert flush_i in the second RUN cycle -> IDLE next cycle with no resp_valid_o; repeat with rst_n_i low instead -> all reset values of REQ-025.
